// File: rtl/point_pkg.sv
// Shared types and constants for the point byte link.
package point_pkg;

    localparam int BYTE_W = 8;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } t_point;

    typedef enum logic [1:0] {
        IDLE,
        SEND_X,
        SEND_Y
    } t_ser_state;

endpackage

// File: rtl/point_fifo.sv
// Small circular FIFO of points; the head entry is read combinationally so the
// serializer can drive its byte outputs straight from storage.
module point_fifo
    import point_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  t_point                   wr_data,
    output t_point                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    t_point            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/point_serializer.sv
// Buffers points and emits each as an x byte then a y byte (byte_last on y)
// over a valid/ready byte stream at up to one byte per clock.
module point_serializer
    import point_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     point_valid,
    input  t_point                   point_i,
    output logic                     point_ready,
    output logic                     byte_valid,
    output logic [BYTE_W-1:0]        byte_data,
    output logic                     byte_last,
    input  logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [COUNT_W-1:0]       sent_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    t_ser_state          state_reg;
    t_ser_state          state_next;
    logic [COUNT_W-1:0]  sent_count_reg;
    t_point              head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    assign point_ready = !fifo_full;
    assign push        = point_valid && point_ready;
    assign pop         = (state_reg == SEND_Y) && byte_ready;
    assign sent_count  = sent_count_reg;

    point_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (point_i),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sent_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                sent_count_reg <= sent_count_reg + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = '0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SEND_X;
                end
            end
            SEND_X: begin
                byte_valid = 1'b1;
                byte_data  = head.x;
                if (byte_ready) begin
                    state_next = SEND_Y;
                end
            end
            SEND_Y: begin
                byte_valid = 1'b1;
                byte_last  = 1'b1;
                byte_data  = head.y;
                // Head is popped here; keep streaming if anything remains or arrives.
                if (byte_ready) begin
                    if ((fifo_count != CNT_W'(1)) || push) begin
                        state_next = SEND_X;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_point_serializer.sv
// Randomized and directed bench for point_serializer against a queue-based
// model of the point link.
module tb_point_serializer;
    import point_pkg::*;

    localparam int DEPTH   = 4;
    localparam int COUNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   point_valid;
    t_point                 point_i;
    logic                   point_ready;
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_last;
    logic                   byte_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [COUNT_W-1:0]     sent_count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered points, plus whether a point is on
    // the link and which of its two bytes is being offered.
    t_point q[$];
    bit     active;
    bit     on_y;
    int     sent;
    bit     known;

    point_serializer #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .point_valid (point_valid),
        .point_i     (point_i),
        .point_ready (point_ready),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .fifo_count  (fifo_count),
        .sent_count  (sent_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit pv, input t_point p, input bit br);
        bit push;
        push = pv && (q.size() != DEPTH);
        if (r) begin
            q.delete();
            active = 0;
            on_y   = 0;
            sent   = 0;
            known  = 1;
            return;
        end
        if (!active) begin
            active = (q.size() != 0);
            on_y   = 0;
        end else if (!on_y) begin
            if (br) on_y = 1;
        end else if (br) begin
            $display("point sent x=%02h y=%02h", q[0].x, q[0].y);
            void'(q.pop_front());
            sent++;
            if (push) q.push_back(p);
            push   = 0;
            active = (q.size() != 0);
            on_y   = 0;
        end
        if (push) q.push_back(p);
    endtask

    task automatic check_outputs();
        logic [7:0] exp_data;
        if (!known) return;
        exp_data = !active ? 8'h00 : (on_y ? q[0].y : q[0].x);
        check_val("byte_valid", 32'(byte_valid), 32'(active));
        check_val("byte_data", 32'(byte_data), 32'(exp_data));
        check_val("byte_last", 32'(byte_last), 32'(active && on_y));
        check_val("fifo_count", 32'(fifo_count), 32'(q.size()));
        check_val("point_ready", 32'(point_ready), 32'(q.size() != DEPTH));
        check_val("sent_count", 32'(sent_count), 32'(sent % (1 << COUNT_W)));
    endtask

    task automatic cycle(input bit r, input bit pv, input logic [15:0] p, input bit br);
        rst         = r;
        point_valid = pv;
        point_i     = p;
        byte_ready  = br;
        @(posedge clk);
        model_edge(r, pv, t_point'(p), br);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        known = 0;
        active = 0;
        on_y = 0;
        sent = 0;
        cycle(1, 0, 16'h0, 0);
        cycle(1, 0, 16'h0, 0);

        // Single point, then let it drain.
        cycle(0, 1, 16'h1234, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 16'h0, 1);

        // Back-to-back stream.
        cycle(0, 1, 16'h01FF, 1);
        cycle(0, 1, 16'h02FE, 1);
        cycle(0, 1, 16'h03FD, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 1);

        // Backpressure on x byte.
        cycle(0, 1, 16'hA55A, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 1);

        // Fill, offer a fifth point, then release.
        for (int i = 0; i < 4; i++) cycle(0, 1, 16'(16'h1000 + i), 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 16'h5555, 0);
        for (int i = 0; i < 14; i++) cycle(0, 1, 16'h5555, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 1);

        // Reset after the x handshake.
        cycle(0, 1, 16'h7788, 0);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 1);

        // Seventeen points so sent_count wraps.
        for (int i = 0; i < 17; i++) begin
            cycle(0, 1, 16'($urandom), 1);
            cycle(0, 0, 16'h0, 1);
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 249) == 0),
                  ($urandom_range(0, 99) < 60),
                  16'($urandom),
                  ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 80 : 35)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
